// File: rtl/game_referee.sv
// Pong match referee: samples the ball once per frame, scores wall misses and
// sequences IDLE -> SERVE -> PLAY -> OVER, gating the ball animation.
module game_referee #(
    parameter int H_SCREEN     = 640,
    parameter int BORDER       = 10,
    parameter int BALL_SIZE    = 10,
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] ball_x,
    input  logic       start,
    output logic [4:0] score_p1,
    output logic [4:0] score_p2,
    output logic [1:0] state,
    output logic       ball_en,
    output logic       ball_reload,
    output logic       serve_dir,
    output logic       point_p1,
    output logic       point_p2,
    output logic       game_over,
    output logic       winner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SERVE = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [9:0] LEFT_LIM   = 10'(BORDER);
    localparam logic [9:0] RIGHT_LIM  = 10'(H_SCREEN - BORDER - BALL_SIZE);
    localparam logic [4:0] WIN        = 5'(WIN_SCORE);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);

    logic [1:0] state_q, state_d;
    logic [4:0] score_p1_q, score_p1_d;
    logic [4:0] score_p2_q, score_p2_d;
    logic [7:0] cnt_q, cnt_d;
    logic       serve_dir_q, serve_dir_d;
    logic       winner_q, winner_d;
    logic       point_p1_q, point_p1_d;
    logic       point_p2_q, point_p2_d;
    logic       start_q;
    logic       ball_en_q, ball_reload_q, game_over_q;

    logic       start_edge;
    logic       miss_l, miss_r;

    assign start_edge = start & ~start_q;
    // Left miss wins when both walls would match.
    assign miss_l = frame_tick && (ball_x <= LEFT_LIM);
    assign miss_r = frame_tick && (ball_x >= RIGHT_LIM) && !(ball_x <= LEFT_LIM);

    always_comb begin
        state_d     = state_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        cnt_d       = cnt_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        point_p1_d  = 1'b0;
        point_p2_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                score_p1_d = 5'd0;
                score_p2_d = 5'd0;
                if (start_edge) begin
                    state_d     = S_SERVE;
                    serve_dir_d = 1'b0;
                    cnt_d       = SERVE_LOAD;
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q <= 8'd1) begin
                        state_d = S_PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (miss_l) begin
                    score_p2_d  = score_p2_q + 5'd1;
                    point_p2_d  = 1'b1;
                    serve_dir_d = 1'b1;
                    if (score_p2_d == WIN) begin
                        state_d  = S_OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = S_SERVE;
                        cnt_d   = SERVE_LOAD;
                    end
                end else if (miss_r) begin
                    score_p1_d  = score_p1_q + 5'd1;
                    point_p1_d  = 1'b1;
                    serve_dir_d = 1'b0;
                    if (score_p1_d == WIN) begin
                        state_d  = S_OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = S_SERVE;
                        cnt_d   = SERVE_LOAD;
                    end
                end
            end
            default: begin
                if (start_edge) begin
                    score_p1_d  = 5'd0;
                    score_p2_d  = 5'd0;
                    serve_dir_d = 1'b0;
                    state_d     = S_SERVE;
                    cnt_d       = SERVE_LOAD;
                end
            end
        endcase
    end

    // Ball gating flags are registered from the next state so they align with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            score_p1_q    <= 5'd0;
            score_p2_q    <= 5'd0;
            cnt_q         <= 8'd0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 1'b0;
            point_p1_q    <= 1'b0;
            point_p2_q    <= 1'b0;
            start_q       <= 1'b1;
            ball_en_q     <= 1'b0;
            ball_reload_q <= 1'b1;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_p1_q    <= score_p1_d;
            score_p2_q    <= score_p2_d;
            cnt_q         <= cnt_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            point_p1_q    <= point_p1_d;
            point_p2_q    <= point_p2_d;
            start_q       <= start;
            ball_en_q     <= (state_d == S_PLAY);
            ball_reload_q <= (state_d != S_PLAY);
            game_over_q   <= (state_d == S_OVER);
        end
    end

    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign state       = state_q;
    assign ball_en     = ball_en_q;
    assign ball_reload = ball_reload_q;
    assign serve_dir   = serve_dir_q;
    assign point_p1    = point_p1_q;
    assign point_p2    = point_p2_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_game_referee.sv
// Scoreboard bench for game_referee: the driver queues hand-computed outputs,
// the monitor pops and compares after each clock edge or an async-reset event.
module tb_game_referee;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic [9:0] ball_x;
    logic       start;
    logic [4:0] score_p1, score_p2;
    logic [1:0] state;
    logic       ball_en, ball_reload, serve_dir, point_p1, point_p2, game_over, winner;

    game_referee #(
        .H_SCREEN(640), .BORDER(10), .BALL_SIZE(10), .WIN_SCORE(11), .SERVE_FRAMES(3)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .ball_x(ball_x), .start(start),
        .score_p1(score_p1), .score_p2(score_p2), .state(state), .ball_en(ball_en),
        .ball_reload(ball_reload), .serve_dir(serve_dir), .point_p1(point_p1),
        .point_p2(point_p2), .game_over(game_over), .winner(winner)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       en;
        logic       rl;
        logic       dir;
        logic       p1;
        logic       p2;
        logic       go;
        logic       win;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] st, input logic [4:0] s1, input logic [4:0] s2,
                                input logic dir, input logic p1, input logic p2, input logic win);
        exp_t e;
        e.st  = st;
        e.s1  = s1;
        e.s2  = s2;
        e.en  = (st == 2'd2);
        e.rl  = (st != 2'd2);
        e.dir = dir;
        e.p1  = p1;
        e.p2  = p2;
        e.go  = (st == 2'd3);
        e.win = win;
        return e;
    endfunction

    // Monitor: winner is only meaningful while game_over is expected high.
    initial begin
        exp_t e;
        exp_t a;
        logic ok;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{state, score_p1, score_p2, ball_en, ball_reload, serve_dir,
                      point_p1, point_p2, game_over, winner};
                ok = (a.st === e.st) && (a.s1 === e.s1) && (a.s2 === e.s2) &&
                     (a.en === e.en) && (a.rl === e.rl) && (a.dir === e.dir) &&
                     (a.p1 === e.p1) && (a.p2 === e.p2) && (a.go === e.go) &&
                     (!e.go || (a.win === e.win));
                n_vec++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL vec%0d t=%0t got st=%0d s1=%0d s2=%0d en=%b rl=%b dir=%b p1=%b p2=%b go=%b win=%b expected st=%0d s1=%0d s2=%0d en=%b rl=%b dir=%b p1=%b p2=%b go=%b win=%b",
                             n_vec, $time, a.st, a.s1, a.s2, a.en, a.rl, a.dir, a.p1, a.p2, a.go, a.win,
                             e.st, e.s1, e.s2, e.en, e.rl, e.dir, e.p1, e.p2, e.go, e.win);
                end
            end
        end
    end

    task automatic step(input logic tk, input logic [9:0] x, input logic st_in, input exp_t e);
        @(negedge clk);
        frame_tick = tk;
        ball_x     = x;
        start      = st_in;
        exp_q.push_back(e);
    endtask

    task automatic serve(input logic [4:0] a, input logic [4:0] b, input logic dir);
        step(1'b1, 10'd300, 1'b0, mk(2'd1, a, b, dir, 1'b0, 1'b0, 1'b0));
        step(1'b1, 10'd300, 1'b0, mk(2'd1, a, b, dir, 1'b0, 1'b0, 1'b0));
        step(1'b1, 10'd300, 1'b0, mk(2'd2, a, b, dir, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b1;
        frame_tick = 1'b0;
        ball_x     = 10'd300;

        // Asynchronous reset with start held high.
        #3;
        reset = 1'b0;
        exp_q.push_back(mk(2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        ->chk_ev;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        step(1'b0, 10'd300, 1'b1, mk(2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 10'd300, 1'b1, mk(2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 10'd300, 1'b0, mk(2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 10'd300, 1'b1, mk(2'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Serve of 3 ticks; wall positions on serve ticks do not score.
        step(1'b1, 10'd0,   1'b1, mk(2'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 10'd300, 1'b0, mk(2'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 10'd620, 1'b0, mk(2'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 10'd300, 1'b0, mk(2'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Near-miss on a tick, and a wall position without a tick.
        step(1'b1, 10'd15,  1'b0, mk(2'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 10'd620, 1'b0, mk(2'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Right miss scores P1, then left miss scores P2.
        step(1'b1, 10'd620, 1'b0, mk(2'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        step(1'b0, 10'd300, 1'b0, mk(2'd1, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        serve(5'd1, 5'd0, 1'b0);
        step(1'b1, 10'd10,  1'b0, mk(2'd1, 5'd1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0));

        for (int i = 2; i <= 10; i++) begin
            serve(5'd1, 5'(i - 1), 1'b1);
            step(1'b1, 10'd0, 1'b0, mk(2'd1, 5'd1, 5'(i), 1'b1, 1'b0, 1'b1, 1'b0));
        end

        // Winning point for P2.
        serve(5'd1, 5'd10, 1'b1);
        step(1'b1, 10'd10,  1'b0, mk(2'd3, 5'd1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1));
        step(1'b1, 10'd0,   1'b0, mk(2'd3, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1));
        step(1'b1, 10'd620, 1'b0, mk(2'd3, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1));
        step(1'b0, 10'd300, 1'b0, mk(2'd3, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1));

        // Restart from OVER clears scores.
        step(1'b0, 10'd300, 1'b1, mk(2'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 10'd300, 1'b0, mk(2'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        serve(5'd0, 5'd0, 1'b0);
        step(1'b1, 10'd620, 1'b0, mk(2'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));

        // Reset between edges while in SERVE with the point pulse still high.
        @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.push_back(mk(2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        ->chk_ev;
        @(negedge clk);
        reset = 1'b1;

        step(1'b0, 10'd300, 1'b0, mk(2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 10'd300, 1'b1, mk(2'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
